// File: rtl/rlbp_s2p_collector.sv
// rlbp_s2p_collector: reassembles MSB-first RLBP serial codes into WIDTH-bit
// words and buffers them in a first-word-fall-through FIFO with a sticky
// overflow flag.
// Optional feature macro: RLBP_S2P_PARITY_EN adds a trailing even-parity bit
// per frame, a PAR state and the sticky parity_err_o output.
module rlbp_s2p_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_data_i,
    input  logic                     s_valid_i,
    input  logic                     s_start_i,
    input  logic                     clr_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o
`ifdef RLBP_S2P_PARITY_EN
    ,
    output logic                     parity_err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIDTH + 1);

`ifdef RLBP_S2P_PARITY_EN
    // Whole payload must be held until the parity bit arrives.
    localparam int SR_W = WIDTH;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    // The last payload bit goes straight into the FIFO, so only
    // WIDTH-1 bits ever need to be held.
    localparam int SR_W = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_nxt;
    logic [SR_W-1:0]   sreg;
    logic [CW-1:0]     cnt;

    logic              start_bit;
    logic              shift_bit;
    logic              last_bit;
    logic              push;
    logic [WIDTH-1:0]  push_word;
`ifdef RLBP_S2P_PARITY_EN
    logic              par_bad;
    logic              par_err_q;
`endif

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic              fifo_full, fifo_empty;
    logic              do_pop, do_wr, drop;
    logic              ovf_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (clr_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and frame control; a start marker always restarts the frame.
    always_comb begin
        state_nxt = state;
        start_bit = 1'b0;
        shift_bit = 1'b0;
        last_bit  = 1'b0;
        push      = 1'b0;
`ifdef RLBP_S2P_PARITY_EN
        push_word = sreg;
        par_bad   = 1'b0;
`else
        push_word = {sreg, s_data_i};
`endif
        if (s_valid_i) begin
            if (s_start_i) begin
                start_bit = 1'b1;
                state_nxt = SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        shift_bit = 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            last_bit = 1'b1;
`ifdef RLBP_S2P_PARITY_EN
                            state_nxt = PAR;
`else
                            push      = 1'b1;
                            state_nxt = IDLE;
`endif
                        end
                    end
`ifdef RLBP_S2P_PARITY_EN
                    PAR: begin
                        // Word is stored even when parity is wrong.
                        push      = 1'b1;
                        par_bad   = (s_data_i != (^sreg));
                        state_nxt = IDLE;
                    end
`endif
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Payload shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clr_i) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (start_bit) begin
            sreg <= SR_W'(s_data_i);
            cnt  <= CW'(1);
        end else if (shift_bit) begin
            sreg <= SR_W'({sreg, s_data_i});
`ifdef RLBP_S2P_PARITY_EN
            cnt  <= last_bit ? CW'(WIDTH) : cnt + CW'(1);
`else
            cnt  <= last_bit ? '0 : cnt + CW'(1);
`endif
        end else if (push) begin
            cnt  <= '0;
        end
    end

    assign fifo_full  = (count == LW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign do_pop     = rd_en_i && !fifo_empty;
    // A full FIFO still accepts the word when a pop frees a slot that edge.
    assign do_wr      = push && (!fifo_full || do_pop);
    assign drop       = push && fifo_full && !do_pop;

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr && !clr_i)
            mem[wr_ptr] <= push_word;
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (clr_i)
            ovf_q <= 1'b0;
        else if (drop)
            ovf_q <= 1'b1;
    end

`ifdef RLBP_S2P_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err_q <= 1'b0;
        else if (clr_i)
            par_err_q <= 1'b0;
        else if (push && par_bad)
            par_err_q <= 1'b1;
    end

    assign parity_err_o = par_err_q;
`endif

    assign rd_data_o = fifo_empty ? '0 : mem[rd_ptr];
    assign empty_o   = fifo_empty;
    assign full_o    = fifo_full;
    assign level_o   = count;
    assign ovf_o     = ovf_q;

endmodule
